// File: rtl/btn_debounce_multi.sv
// Debounces N_CH buttons on one shared sample tick; per channel: clean level, press/release, long and repeat pulses.
// Latency <= DEPTH*TICK_DIV+3 clk from a stable input to o_level; no backpressure, every output is a single-clk pulse or level.
module btn_debounce_multi #(
    parameter int TICK_DIV     = 100_000,
    parameter int DEPTH        = 8,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int N_CH         = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);
    localparam int TW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LONG_C    = CW'(LONG_TICKS);
    localparam logic [CW-1:0] REP_C     = CW'(REPEAT_TICKS);
    localparam bit            REP_EN    = (REPEAT_TICKS != 0);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [DEPTH-1:0] sr [N_CH];
    logic [N_CH-1:0]  level_nxt;
    logic [N_CH-1:0]  level_d;
    state_t           state     [N_CH];
    state_t           state_nxt [N_CH];
    logic [CW-1:0]    cnt       [N_CH];
    logic [CW-1:0]    cnt_nxt   [N_CH];

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_btn;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (rst) begin
                sr[c] <= '0;
            end else if (tick) begin
                sr[c] <= {sync2[c], sr[c][DEPTH-1:1]};
            end
        end
    end

    // Hysteresis: only a full window of equal samples moves the level.
    always_comb begin
        level_nxt = o_level;
        for (int c = 0; c < N_CH; c++) begin
            if (&sr[c]) begin
                level_nxt[c] = 1'b1;
            end else if (~|sr[c]) begin
                level_nxt[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_level <= '0;
            level_d <= '0;
        end else begin
            o_level <= level_nxt;
            level_d <= o_level;
        end
    end

    assign o_press   = o_level & ~level_d;
    assign o_release = ~o_level & level_d;

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (rst) begin
                state[c] <= IDLE;
                cnt[c]   <= '0;
            end else begin
                state[c] <= state_nxt[c];
                cnt[c]   <= cnt_nxt[c];
            end
        end
    end

    // A release about to land (level_nxt low) wins over a long/repeat due this cycle.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_nxt[c] = state[c];
            cnt_nxt[c]   = cnt[c];
            if (!level_nxt[c]) begin
                state_nxt[c] = IDLE;
                cnt_nxt[c]   = '0;
            end else begin
                case (state[c])
                    IDLE: begin
                        cnt_nxt[c] = '0;
                        if (o_press[c]) begin
                            state_nxt[c] = PRESSED;
                        end
                    end
                    PRESSED: begin
                        if (cnt[c] == LONG_C) begin
                            state_nxt[c] = HELD;
                            cnt_nxt[c]   = '0;
                        end else if (tick) begin
                            cnt_nxt[c] = cnt[c] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!REP_EN || cnt[c] == REP_C) begin
                            cnt_nxt[c] = '0;
                        end else if (tick) begin
                            cnt_nxt[c] = cnt[c] + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt[c] = IDLE;
                        cnt_nxt[c]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_long   = '0;
        o_repeat = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_long[c]   = level_nxt[c] && (state[c] == PRESSED) && (cnt[c] == LONG_C);
            o_repeat[c] = REP_EN && level_nxt[c] && (state[c] == HELD) && (cnt[c] == REP_C);
        end
    end
endmodule
